// File: rtl/xpu_pkg.sv
// Shared XPU definitions: timer widths, prescaler constants and the
// beacon-sync state encoding.
package xpu_pkg;

   localparam int unsigned COUNT_TOP_1M    = 99;
   localparam int unsigned TSF_TIMER_WIDTH = 64;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_COLLECT  = 3'd1;
   localparam logic [2:0] ST_WAIT_FCS = 3'd2;
   localparam logic [2:0] ST_COMPUTE  = 3'd3;
   localparam logic [2:0] ST_LOAD     = 3'd4;
   localparam logic [2:0] ST_RELEASE  = 3'd5;

endpackage

// File: rtl/tsf_beacon_sync.sv
// Beacon TSF synchronisation: assembles the received timestamp, and on a good
// FCS loads the local timer when the remote time is ahead of the local one.
module tsf_beacon_sync
   import xpu_pkg::*;
#(
   parameter int unsigned TIMER_WIDTH = TSF_TIMER_WIDTH,
   parameter int unsigned LOAD_HOLD   = 4,
   parameter int unsigned FCS_TIMEOUT = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [TIMER_WIDTH-1:0] tsf_runtime_val,
   input  logic                   ts_start,
   input  logic                   ts_byte_valid,
   input  logic [7:0]             ts_byte,
   input  logic                   fcs_ok,
   input  logic                   fcs_bad,
   input  logic [15:0]            latency_comp,
   output logic                   tsf_load_control,
   output logic [TIMER_WIDTH-1:0] tsf_load_val,
   output logic                   sync_done,
   output logic [15:0]            sync_count,
   output logic                   busy
);

   localparam int unsigned TCW = $clog2(FCS_TIMEOUT + 1);
   localparam int unsigned HCW = $clog2(LOAD_HOLD + 1);
   localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(FCS_TIMEOUT - 1);
   localparam logic [HCW-1:0] HOLD_LAST    = HCW'(LOAD_HOLD - 1);

   logic [2:0]             state;
   logic [TIMER_WIDTH-1:0] tsf_cap;
   logic [63:0]            rx_ts;
   logic [TIMER_WIDTH-1:0] offset;
   logic [TIMER_WIDTH-1:0] load_val_q;
   logic [2:0]             byte_cnt;
   logic [TCW-1:0]         timeout_cnt;
   logic [HCW-1:0]         hold_cnt;
   logic                   load_ctrl_q;
   logic [15:0]            count_q;
   logic [TIMER_WIDTH-1:0] cand;
   logic [TIMER_WIDTH-1:0] release_val;

   assign cand        = TIMER_WIDTH'(rx_ts) + TIMER_WIDTH'(latency_comp);
   assign release_val = tsf_runtime_val + TIMER_WIDTH'(1) + offset;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         tsf_cap     <= '0;
         rx_ts       <= '0;
         offset      <= '0;
         load_val_q  <= '0;
         byte_cnt    <= '0;
         timeout_cnt <= '0;
         hold_cnt    <= '0;
         load_ctrl_q <= 1'b0;
         count_q     <= '0;
      end else begin
         case (state)
            // A new ts_start restarts capture from any of the receive states.
            ST_IDLE, ST_COLLECT, ST_WAIT_FCS: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (ts_start) begin
                  tsf_cap     <= tsf_runtime_val;
                  timeout_cnt <= '0;
                  state       <= ST_COLLECT;
                  if (ts_byte_valid) begin
                     rx_ts[7:0] <= ts_byte;
                     byte_cnt   <= 3'd1;
                  end else begin
                     byte_cnt   <= '0;
                  end
               end else if (state == ST_COLLECT) begin
                  if (fcs_ok || fcs_bad) begin
                     state <= ST_IDLE;
                  end else if (ts_byte_valid) begin
                     rx_ts[{byte_cnt, 3'b000} +: 8] <= ts_byte;
                     byte_cnt <= byte_cnt + 3'd1;
                     if (byte_cnt == 3'd7) begin
                        timeout_cnt <= '0;
                        state       <= ST_WAIT_FCS;
                     end
                  end
               end else if (state == ST_WAIT_FCS) begin
                  if (fcs_ok) begin
                     state <= ST_COMPUTE;
                  end else if (fcs_bad || timeout_cnt == TIMEOUT_LAST) begin
                     state <= ST_IDLE;
                  end else begin
                     timeout_cnt <= timeout_cnt + 1'b1;
                  end
               end
            end
            ST_COMPUTE: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (cand > tsf_cap) begin
                  offset      <= cand - tsf_cap;
                  hold_cnt    <= '0;
                  load_ctrl_q <= 1'b1;
                  state       <= ST_LOAD;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (hold_cnt == HOLD_LAST) begin
                  load_ctrl_q <= 1'b0;
                  state       <= ST_RELEASE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            ST_RELEASE: begin
               load_val_q <= release_val;
               count_q    <= count_q + 16'd1;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The load value tracks the live timer during RELEASE, then freezes.
   assign tsf_load_val     = (state == ST_RELEASE) ? release_val : load_val_q;
   assign tsf_load_control = load_ctrl_q;
   assign sync_done        = (state == ST_RELEASE);
   assign sync_count       = count_q;
   assign busy             = (state != ST_IDLE);

endmodule

// File: tb/tb_tsf_beacon_sync.sv
// Bench for tsf_beacon_sync: directed vector table, hand-written corner
// sequences and randomized frames against an arithmetic reference model.
module tb_tsf_beacon_sync;

   localparam int unsigned LOAD_HOLD   = 4;
   localparam int unsigned FCS_TIMEOUT = 4096;
   localparam int unsigned V_OK  = 1;
   localparam int unsigned V_BAD = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [63:0] tsf_runtime_val;
   logic        ts_start;
   logic        ts_byte_valid;
   logic [7:0]  ts_byte;
   logic        fcs_ok;
   logic        fcs_bad;
   logic [15:0] latency_comp;
   logic        tsf_load_control;
   logic [63:0] tsf_load_val;
   logic        sync_done;
   logic [15:0] sync_count;
   logic        busy;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [15:0] exp_count = '0;

   tsf_beacon_sync #(
      .TIMER_WIDTH(64),
      .LOAD_HOLD  (LOAD_HOLD),
      .FCS_TIMEOUT(FCS_TIMEOUT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .tsf_runtime_val (tsf_runtime_val),
      .ts_start        (ts_start),
      .ts_byte_valid   (ts_byte_valid),
      .ts_byte         (ts_byte),
      .fcs_ok          (fcs_ok),
      .fcs_bad         (fcs_bad),
      .latency_comp    (latency_comp),
      .tsf_load_control(tsf_load_control),
      .tsf_load_val    (tsf_load_val),
      .sync_done       (sync_done),
      .sync_count      (sync_count),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string       name;
      logic [63:0] cap;
      logic [63:0] ts;
      logic [15:0] lat;
      int unsigned nbytes;
      int unsigned verdict;
      logic        exp_load;
      logic [63:0] exp_off;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock; the live TSF increments once per cycle.
   task automatic step();
      @(posedge clk);
      #1 tsf_runtime_val = tsf_runtime_val + 64'd1;
      #1;
   endtask

   task automatic start_frame(input logic [63:0] cap, input logic [63:0] ts, input int unsigned nbytes);
      tsf_runtime_val = cap;
      ts_start        = 1'b1;
      ts_byte_valid   = 1'b1;
      ts_byte         = ts[7:0];
      step();
      ts_start = 1'b0;
      for (int unsigned i = 1; i < nbytes; i++) begin
         ts_byte = ts[8*i +: 8];
         step();
      end
      ts_byte_valid = 1'b0;
   endtask

   task automatic run_frame(input string name, input logic [63:0] cap, input logic [63:0] ts,
                            input logic [15:0] lat, input int unsigned nbytes, input int unsigned verdict,
                            input logic exp_load, input logic [63:0] exp_off, input logic drop_en);
      int unsigned iters = 0;
      int unsigned hold = 0;
      int unsigned done = 0;
      int unsigned exp_iters;
      logic [63:0] saved = '0;
      enable       = 1'b1;
      latency_comp = lat;
      start_frame(cap, ts, nbytes);
      fcs_ok  = (verdict == V_OK);
      fcs_bad = (verdict == V_BAD);
      step();
      fcs_ok  = 1'b0;
      fcs_bad = 1'b0;
      while (busy && iters < 30) begin
         iters++;
         if (tsf_load_control) begin
            hold++;
            if (drop_en) enable = 1'b0;
         end
         if (sync_done) begin
            done++;
            chk({name, "_load_val"}, tsf_load_val, tsf_runtime_val + 64'd1 + exp_off);
            saved = tsf_load_val;
         end
         step();
      end
      exp_iters = exp_load ? (2 + LOAD_HOLD) : ((verdict == V_OK && nbytes == 8) ? 1 : 0);
      if (exp_load) exp_count = exp_count + 16'd1;
      chk({name, "_busy_cycles"}, 64'(iters), 64'(exp_iters));
      chk({name, "_hold"}, 64'(hold), exp_load ? 64'(LOAD_HOLD) : 64'd0);
      chk({name, "_sync_done"}, 64'(done), exp_load ? 64'd1 : 64'd0);
      chk({name, "_sync_count"}, 64'(sync_count), 64'(exp_count));
      if (exp_load) begin
         step();
         chk({name, "_val_hold"}, tsf_load_val, saved);
      end
      enable = 1'b1;
   endtask

   initial begin
      logic [63:0] cap, ts, cand;
      logic [15:0] lat;
      int unsigned nb, vd;
      logic        el;

      vecs[0] = '{"adopt",     64'd1000, 64'd5000, 16'd20, 8, V_OK,  1'b1, 64'd4020};
      vecs[1] = '{"reject",    64'd9000, 64'd5000, 16'd20, 8, V_OK,  1'b0, 64'd0};
      vecs[2] = '{"fcs_bad",   64'd1000, 64'd5000, 16'd20, 8, V_BAD, 1'b0, 64'd0};
      vecs[3] = '{"short_ok",  64'd1000, 64'd5000, 16'd20, 5, V_OK,  1'b0, 64'd0};
      vecs[4] = '{"wrap",      64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFF0, 16'h0020, 8, V_OK, 1'b0, 64'd0};
      vecs[5] = '{"equal",     64'd5020, 64'd5000, 16'd20, 8, V_OK,  1'b0, 64'd0};
      vecs[6] = '{"plus_one",  64'd5019, 64'd5000, 16'd20, 8, V_OK,  1'b1, 64'd1};
      vecs[7] = '{"max_lat",   64'd0,    64'd0,    16'hFFFF, 8, V_OK, 1'b1, 64'hFFFF};

      rst = 1'b1; enable = 1'b1; tsf_runtime_val = 64'd50;
      ts_start = 1'b0; ts_byte_valid = 1'b0; ts_byte = '0;
      fcs_ok = 1'b0; fcs_bad = 1'b0; latency_comp = '0;
      step();
      step();
      chk("rst_load_control", 64'(tsf_load_control), 64'd0);
      chk("rst_load_val", tsf_load_val, 64'd0);
      chk("rst_sync_done", 64'(sync_done), 64'd0);
      chk("rst_sync_count", 64'(sync_count), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      step();

      foreach (vecs[i])
         run_frame(vecs[i].name, vecs[i].cap, vecs[i].ts, vecs[i].lat, vecs[i].nbytes,
                   vecs[i].verdict, vecs[i].exp_load, vecs[i].exp_off, 1'b0);

      // Restart from COLLECT and from WAIT_FCS.
      start_frame(64'd100, 64'd0, 3);
      run_frame("restart_collect", 64'd2000, 64'd7000, 16'd0, 8, V_OK, 1'b1, 64'd5000, 1'b0);
      start_frame(64'd100, 64'd0, 8);
      run_frame("restart_wait", 64'd2000, 64'd7000, 16'd5, 8, V_OK, 1'b1, 64'd5005, 1'b0);

      // enable dropped during LOAD must not cut the load short.
      run_frame("en_drop_load", 64'd1000, 64'd5000, 16'd20, 8, V_OK, 1'b1, 64'd4020, 1'b1);

      // Verdict timeout.
      start_frame(64'd100, 64'd500, 8);
      for (int unsigned i = 0; i < FCS_TIMEOUT - 1; i++) step();
      chk("timeout_still_busy", 64'(busy), 64'd1);
      step();
      chk("timeout_idle", 64'(busy), 64'd0);
      chk("timeout_count", 64'(sync_count), 64'(exp_count));

      // Reset on the second LOAD cycle.
      latency_comp = 16'd20;
      start_frame(64'd1000, 64'd5000, 8);
      fcs_ok = 1'b1;
      step();
      fcs_ok = 1'b0;
      step();
      chk("rstload_cycle1", 64'(tsf_load_control), 64'd1);
      step();
      chk("rstload_cycle2", 64'(tsf_load_control), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_count = '0;
      chk("rstload_ctrl_low", 64'(tsf_load_control), 64'd0);
      chk("rstload_busy", 64'(busy), 64'd0);
      chk("rstload_count", 64'(sync_count), 64'd0);
      chk("rstload_val", tsf_load_val, 64'd0);
      for (int unsigned i = 0; i < LOAD_HOLD + 2; i++) begin
         chk("rstload_no_done", 64'(sync_done | tsf_load_control), 64'd0);
         step();
      end

      // Randomized frames against the arithmetic model.
      for (int unsigned r = 0; r < 40; r++) begin
         cap = {$urandom, $urandom};
         if ($urandom_range(0, 4) == 0) ts = {$urandom, $urandom};
         else ts = cap + 64'($urandom_range(0, 4000)) - 64'd2000;
         lat = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 40));
         nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
         vd  = ($urandom_range(0, 3) == 0) ? V_BAD : V_OK;
         cand = ts + {48'd0, lat};
         el   = (nb == 8) && (vd == V_OK) && (cand > cap);
         run_frame($sformatf("rand%0d", r), cap, ts, lat, nb, vd, el, cand - cap,
                   1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
